// File: rtl/rs_pkg.sv
// ---------------------------------------------------------------------------
// rs_pkg
// Shared definitions for the RS(255,239) block encoder over GF(2^8):
//   - code geometry (RS_N, RS_K, PAR_N = 2T) and counter width
//   - field polynomial and a GF(2^8) multiply helper
//   - generator coefficients g_0..g_{2T-1}, roots alpha^0..alpha^{2T-1}
//   - FSM state encoding
// ---------------------------------------------------------------------------
package rs_pkg;

    localparam int RS_N  = 255;
    localparam int RS_K  = 239;
    localparam int PAR_N = RS_N - RS_K;  // 2T parity symbols
    localparam int CNT_W = 10;

    localparam logic [8:0] GF_POLY = 9'h11D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_PAD
    } enc_state_e;

    typedef logic [PAR_N-1:0][7:0] coef_vec_t;

    // Shift-and-add multiply, reducing by GF_POLY whenever x overflows.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0]) : {x[6:0], 1'b0};
        end
        return acc;
    endfunction

    // Expands prod (x + alpha^i) one root at a time; g[PAR_N] stays 1 (monic).
    function automatic coef_vec_t gen_g_coef();
        logic [PAR_N:0][7:0] g;
        logic [7:0]          root;
        coef_vec_t           res;
        g    = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < PAR_N; i++) begin
            for (int k = PAR_N; k >= 1; k--) begin
                g[k] = g[k-1] ^ gf_mul(g[k], root);
            end
            g[0] = gf_mul(g[0], root);
            root = gf_mul(root, 8'h02);
        end
        for (int j = 0; j < PAR_N; j++) res[j] = g[j];
        return res;
    endfunction

    localparam coef_vec_t G_COEF = gen_g_coef();

endpackage

// File: rtl/rs_block_encoder_if.sv
// ---------------------------------------------------------------------------
// rs_block_encoder_if
// Symbol stream into and out of the RS encoder.
//   i_sof, i_data, i_rs_data_symbol, i_rs_check_symbol : framer -> encoder
//   o_sof, o_data, o_rs_data_symbol, o_rs_check_symbol : encoder -> serializer
//   o_blk_err                                          : protocol error pulse
// master: the side driving the input stream; slave: the encoder.
// ---------------------------------------------------------------------------
interface rs_block_encoder_if;
    logic       i_sof;
    logic [7:0] i_data;
    logic       i_rs_data_symbol;
    logic       i_rs_check_symbol;
    logic       o_sof;
    logic [7:0] o_data;
    logic       o_rs_data_symbol;
    logic       o_rs_check_symbol;
    logic       o_blk_err;

    modport master (
        output i_sof, i_data, i_rs_data_symbol, i_rs_check_symbol,
        input  o_sof, o_data, o_rs_data_symbol, o_rs_check_symbol, o_blk_err
    );

    modport slave (
        input  i_sof, i_data, i_rs_data_symbol, i_rs_check_symbol,
        output o_sof, o_data, o_rs_data_symbol, o_rs_check_symbol, o_blk_err
    );
endinterface

// File: rtl/gf256_const_mul.sv
// ---------------------------------------------------------------------------
// gf256_const_mul
// Combinational GF(2^8) multiply of a_i by the constant COEF; with a constant
// operand this reduces to a small XOR network.
//   a_i : 8-bit operand
//   y_o : a_i * COEF in GF(2^8) / GF_POLY
// ---------------------------------------------------------------------------
module gf256_const_mul
    import rs_pkg::*;
#(
    parameter logic [7:0] COEF = 8'h01
) (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    assign y_o = gf_mul(a_i, COEF);
endmodule

// File: rtl/rs_block_encoder.sv
// ---------------------------------------------------------------------------
// rs_block_encoder
// Systematic RS(255,239) encoder. Data symbols pass through and feed the
// parity LFSR; in the check-symbol window the 2T parity bytes are shifted
// out, then zero pad bytes for any excess check slots. All outputs are
// registered one cycle after their inputs.
//   i_clk : clock
//   i_rst : asynchronous reset, active high
//   bus   : stream interface (slave), including the o_blk_err pulse
// ---------------------------------------------------------------------------
module rs_block_encoder
    import rs_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    rs_block_encoder_if.slave bus
);
    enc_state_e            state_q, state_d;
    logic [PAR_N-1:0][7:0] p_q, p_d;
    logic [CNT_W-1:0]      data_cnt_q, data_cnt_d;
    logic [CNT_W-1:0]      check_cnt_q, check_cnt_d;
    logic [CNT_W-1:0]      chk_pos;
    logic                  pending_q, pending_d;  // parity computed but not fully emitted
    logic [7:0]            data_q, data_d;
    logic                  err_q, err_d;
    logic                  sof_q, dsym_q, csym_q;

    logic       data_in, chk_in, blk_start, sof_abort;
    logic [7:0] fb;
    logic [7:0] fb_mul [PAR_N];

    // A data strobe always wins over a simultaneous check strobe.
    assign data_in   = bus.i_rs_data_symbol;
    assign chk_in    = bus.i_rs_check_symbol & ~data_in;
    assign blk_start = data_in & (bus.i_sof | (state_q != ST_DATA));
    assign sof_abort = bus.i_sof & ~data_in;

    // At block start the old parity is ignored, i.e. treated as zero.
    assign fb      = bus.i_data ^ (blk_start ? 8'h00 : p_q[PAR_N-1]);
    assign chk_pos = (state_q == ST_DATA) ? '0 : check_cnt_q;

    for (genvar j = 0; j < PAR_N; j++) begin : g_mul
        gf256_const_mul #(.COEF(G_COEF[j])) u_mul (
            .a_i (fb),
            .y_o (fb_mul[j])
        );
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        p_d         = p_q;
        data_cnt_d  = data_cnt_q;
        check_cnt_d = check_cnt_q;
        pending_d   = pending_q;
        data_d      = 8'h00;
        err_d       = 1'b0;

        if (data_in) begin
            state_d   = ST_DATA;
            data_d    = bus.i_data;
            pending_d = 1'b1;
            p_d[0]    = fb_mul[0];
            for (int j = 1; j < PAR_N; j++) begin
                p_d[j] = (blk_start ? 8'h00 : p_q[j-1]) ^ fb_mul[j];
            end
            if (blk_start)                data_cnt_d = CNT_W'(1);
            else if (data_cnt_q != '1)    data_cnt_d = data_cnt_q + CNT_W'(1);
            err_d = bus.i_rs_check_symbol | (blk_start & pending_q);
        end else if (sof_abort) begin
            // New frame while outside a data run: drop any leftover parity.
            p_d       = '0;
            pending_d = 1'b0;
            err_d     = pending_q;
            state_d   = chk_in ? ST_PAD : ST_IDLE;
        end else if (chk_in) begin
            unique case (state_q)
                ST_DATA, ST_PARITY: begin
                    data_d      = p_q[PAR_N-1];
                    p_d         = {p_q[PAR_N-2:0], 8'h00};
                    check_cnt_d = chk_pos + CNT_W'(1);
                    if (chk_pos == CNT_W'(PAR_N-1)) begin
                        state_d   = ST_PAD;
                        pending_d = 1'b0;
                    end else begin
                        state_d = ST_PARITY;
                    end
                    err_d = (state_q == ST_DATA) && (data_cnt_q != CNT_W'(RS_K));
                end
                default: begin
                    // Excess check slots, or a check window with no data run.
                    state_d = ST_PAD;
                    if (check_cnt_q != '1) check_cnt_d = check_cnt_q + CNT_W'(1);
                end
            endcase
        end else begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            // NOTE: the parity array is reset like any other register so a
            // partial codeword can never be emitted after reset release.
            p_q         <= '0;
            data_cnt_q  <= '0;
            check_cnt_q <= '0;
            pending_q   <= 1'b0;
            data_q      <= 8'h00;
            err_q       <= 1'b0;
            sof_q       <= 1'b0;
            dsym_q      <= 1'b0;
            csym_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            p_q         <= p_d;
            data_cnt_q  <= data_cnt_d;
            check_cnt_q <= check_cnt_d;
            pending_q   <= pending_d;
            data_q      <= data_d;
            err_q       <= err_d;
            sof_q       <= bus.i_sof;
            dsym_q      <= bus.i_rs_data_symbol;
            csym_q      <= bus.i_rs_check_symbol;
        end
    end

    assign bus.o_sof             = sof_q;
    assign bus.o_data            = data_q;
    assign bus.o_rs_data_symbol  = dsym_q;
    assign bus.o_rs_check_symbol = csym_q;
    assign bus.o_blk_err         = err_q;

endmodule

// File: tb/tb_rs_block_encoder.sv
// ---------------------------------------------------------------------------
// tb_rs_block_encoder
// Self-checking bench for rs_block_encoder. Expected outputs come from a
// frame-level model: messages are collected per block and the parity is the
// remainder of m(x)*x^16 by g(x), found by polynomial long division with
// log/antilog tables.
// ---------------------------------------------------------------------------
module tb_rs_block_encoder;

    localparam int NPAR = 16;
    localparam int K    = 239;

    logic clk = 1'b0;
    logic rst = 1'b1;

    rs_block_encoder_if bus ();

    rs_block_encoder dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    logic [11:0] last_act;  // {sof, dsym, csym, data[7:0], err}

    // GF(2^8) tables and generator (lowest degree first, gen_lo[16] = 1)
    int gexp [512];
    int glog [256];
    int gen_lo [17];

    // Reference model state
    int  m_msg [$];
    int  m_par [NPAR];
    int  m_pos;
    bit  m_prev_data;
    bit  m_pending;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int gmul(input int x, input int y);
        if (x == 0 || y == 0) return 0;
        return gexp[glog[x] + glog[y]];
    endfunction

    task automatic build_tables();
        int x;
        int tmp [17];
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = x;
            glog[x] = i;
            x = x << 1;
            if (x >= 256) x = x ^ 'h11D;
        end
        for (int i = 255; i < 512; i++) gexp[i] = gexp[i-255];
        for (int k = 0; k <= NPAR; k++) gen_lo[k] = 0;
        gen_lo[0] = 1;
        for (int i = 0; i < NPAR; i++) begin
            // gen <- gen * (x + alpha^i)
            for (int k = 0; k <= NPAR; k++) tmp[k] = gmul(gexp[i], gen_lo[k]);
            for (int k = 1; k <= NPAR; k++) tmp[k] = tmp[k] ^ gen_lo[k-1];
            for (int k = 0; k <= NPAR; k++) gen_lo[k] = tmp[k];
        end
    endtask

    // Long division of m(x)*x^16 by g(x); remainder listed highest degree first.
    task automatic compute_parity();
        int a [$];
        int n;
        n = m_msg.size();
        a = m_msg;
        for (int i = 0; i < NPAR; i++) a.push_back(0);
        for (int i = 0; i < n; i++) begin
            int c;
            c = a[i];
            if (c != 0) begin
                for (int j = 0; j <= NPAR; j++) a[i+j] = a[i+j] ^ gmul(c, gen_lo[NPAR-j]);
            end
        end
        for (int k = 0; k < NPAR; k++) m_par[k] = a[n+k];
    endtask

    task automatic model_step(input logic r, input logic s, input logic ds, input logic cs,
                              input logic [7:0] d, output logic [11:0] e);
        logic [7:0] ed;
        logic       ee;
        bit         start;
        ed = 8'h00;
        ee = 1'b0;
        if (r) begin
            m_msg.delete();
            m_pos       = NPAR;
            m_prev_data = 1'b0;
            m_pending   = 1'b0;
            e = '0;
            return;
        end
        if (ds) begin
            start = s || !m_prev_data;
            if (start) begin
                ee = m_pending;
                m_msg.delete();
            end
            if (cs) ee = 1'b1;
            m_msg.push_back(int'(d));
            ed          = d;
            m_pending   = 1'b1;
            m_prev_data = 1'b1;
            m_pos       = NPAR;
        end else if (s) begin
            ee = m_pending;
            m_pending   = 1'b0;
            m_pos       = NPAR;
            m_prev_data = 1'b0;
            m_msg.delete();
        end else if (cs) begin
            if (m_prev_data) begin
                ee = (m_msg.size() != K);
                compute_parity();
                m_pos = 0;
            end
            if (m_pos < NPAR) begin
                ed = 8'(m_par[m_pos]);
                m_pos++;
                if (m_pos == NPAR) m_pending = 1'b0;
            end
            m_prev_data = 1'b0;
        end else begin
            m_pos       = NPAR;
            m_prev_data = 1'b0;
        end
        e = {s, ds, cs, ed, ee};
    endtask

    task automatic drive(input logic r, input logic s, input logic ds, input logic cs,
                         input logic [7:0] d);
        rst                   = r;
        bus.i_sof             = s;
        bus.i_rs_data_symbol  = ds;
        bus.i_rs_check_symbol = cs;
        bus.i_data            = d;
        @(posedge clk);
        #1;
        last_act = {bus.o_sof, bus.o_rs_data_symbol, bus.o_rs_check_symbol,
                    bus.o_data, bus.o_blk_err};
        if (last_act[0] === 1'b1) err_seen++;
    endtask

    task automatic run_cycle(input string name, input logic r, input logic s, input logic ds,
                             input logic cs, input logic [7:0] d);
        logic [11:0] e;
        model_step(r, s, ds, cs, d, e);
        drive(r, s, ds, cs, d);
        check(name, 32'(last_act), 32'(e));
    endtask

    task automatic send_data(input string name, input int q [$], input bit with_sof);
        for (int i = 0; i < q.size(); i++)
            run_cycle(name, 1'b0, with_sof && (i == 0), 1'b1, 1'b0, 8'(q[i]));
    endtask

    task automatic send_checks(input string name, input int n);
        for (int i = 0; i < n; i++) run_cycle(name, 1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
    endtask

    task automatic impulse_window(input string name);
        for (int k = 0; k < 23; k++) begin
            run_cycle(name, 1'b0, 1'b0, 1'b0, 1'b1, 8'($urandom));
            if (k < NPAR) check({name, "_gcoef"}, 32'(last_act[8:1]), 32'(gen_lo[NPAR-1-k]));
            else          check({name, "_pad"}, 32'(last_act[8:1]), 32'h0);
        end
    endtask

    typedef struct {
        logic       r, s, ds, cs;
        logic [7:0] d;
        logic       e_sof, e_ds, e_cs;
        logic [7:0] e_d;
        logic       e_err;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int q [$];
        int len, nchk;

        bus.i_sof = 1'b0; bus.i_data = 8'h00;
        bus.i_rs_data_symbol = 1'b0; bus.i_rs_check_symbol = 1'b0;
        build_tables();

        // Reset held with random inputs
        for (int i = 0; i < 3; i++)
            run_cycle("rst_hold", 1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));

        //          r  s  ds cs d      sof ds cs data   err
        tbl[0]  = '{1, 1, 1, 1, 8'hA5, 0, 0, 0, 8'h00, 0};
        tbl[1]  = '{1, 0, 1, 0, 8'h3C, 0, 0, 0, 8'h00, 0};
        tbl[2]  = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0};
        tbl[3]  = '{0, 0, 0, 1, 8'h77, 0, 0, 1, 8'h00, 0};
        tbl[4]  = '{0, 0, 1, 0, 8'h11, 0, 1, 0, 8'h11, 0};
        tbl[5]  = '{0, 0, 1, 1, 8'h22, 0, 1, 1, 8'h22, 1};
        tbl[6]  = '{0, 0, 1, 0, 8'h33, 0, 1, 0, 8'h33, 0};
        tbl[7]  = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0};
        tbl[8]  = '{0, 1, 1, 0, 8'h44, 1, 1, 0, 8'h44, 1};
        tbl[9]  = '{0, 1, 0, 0, 8'h00, 1, 0, 0, 8'h00, 1};
        tbl[10] = '{0, 0, 0, 1, 8'h55, 0, 0, 1, 8'h00, 0};
        tbl[11] = '{1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0};
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].ds, tbl[i].cs, tbl[i].d);
            check($sformatf("vec%0d", i), 32'(last_act),
                  32'({tbl[i].e_sof, tbl[i].e_ds, tbl[i].e_cs, tbl[i].e_d, tbl[i].e_err}));
        end

        run_cycle("resync", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        run_cycle("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // All-zero block
        err_seen = 0;
        q.delete();
        for (int i = 0; i < K; i++) q.push_back(0);
        send_data("zero_blk", q, 1'b1);
        send_checks("zero_chk", 23);
        run_cycle("zero_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("zero_err_cnt", 32'(err_seen), 32'd0);

        // Impulse block: parity equals generator coefficients
        q[K-1] = 1;
        send_data("imp_blk", q, 1'b1);
        impulse_window("imp_chk");

        // Back-to-back: zero block then impulse block, no gap
        q[K-1] = 0;
        send_data("b2b_a", q, 1'b1);
        send_checks("b2b_a_chk", 23);
        q[K-1] = 1;
        send_data("b2b_b", q, 1'b1);
        impulse_window("b2b_b_chk");
        run_cycle("b2b_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Short block of 100 symbols
        err_seen = 0;
        q.delete();
        for (int i = 0; i < 100; i++) q.push_back(int'($urandom_range(0, 255)));
        send_data("short_blk", q, 1'b1);
        send_checks("short_chk", 23);
        check("short_err_cnt", 32'(err_seen), 32'd1);

        // Both strobes high on one data cycle
        err_seen = 0;
        for (int i = 0; i < K; i++)
            run_cycle("both_blk", 1'b0, i == 0, 1'b1, i == 50, 8'($urandom));
        send_checks("both_chk", 23);
        check("both_err_cnt", 32'(err_seen), 32'd1);

        // Reset asserted in the middle of the parity window
        for (int i = 0; i < K; i++)
            run_cycle("pre_rst_blk", 1'b0, i == 0, 1'b1, 1'b0, 8'($urandom));
        send_checks("pre_rst_chk", 5);
        run_cycle("mid_rst", 1'b1, 1'b0, 1'b0, 1'b1, 8'($urandom));
        check("mid_rst_zero", 32'(last_act), 32'h0);
        run_cycle("post_rst_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        run_cycle("post_rst_chk", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < K; i++)
            run_cycle("post_rst_blk", 1'b0, i == 0, 1'b1, 1'b0, 8'($urandom));
        send_checks("post_rst_par", 16);

        // Randomized frames: lengths, gaps, window sizes and sof placement
        for (int b = 0; b < 14; b++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) run_cycle("rnd_gap", 1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));
            len  = ($urandom_range(0, 1) == 1) ? K : $urandom_range(1, 300);
            nchk = ($urandom_range(0, 1) == 1) ? 23 : $urandom_range(0, 30);
            q.delete();
            for (int i = 0; i < len; i++) q.push_back(int'($urandom_range(0, 255)));
            send_data($sformatf("rnd%0d_dat", b), q, $urandom_range(0, 3) != 0);
            send_checks($sformatf("rnd%0d_chk", b), nchk);
            if ($urandom_range(0, 4) == 0)
                run_cycle("rnd_sof", 1'b0, 1'b1, 1'b0, 1'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
